// File: rtl/lv1_lv2_bus_arbiter.sv
// Round-robin arbiter for the shared lv1-lv2 bus: one processor grant plus a nested snoop grant.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module lv1_lv2_bus_arbiter #(
    parameter int NUM_CORE    = 4,
    parameter int ARB_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CORE-1:0] bus_lv1_lv2_req_proc,
    input  logic [NUM_CORE-1:0] bus_lv1_lv2_req_snoop,
    output logic [NUM_CORE-1:0] bus_lv1_lv2_gnt_proc,
    output logic [NUM_CORE-1:0] bus_lv1_lv2_gnt_snoop,
    output logic                arb_busy,
    output logic                timeout_err
);

    localparam int IDX_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PROC       = 2'd1,
        PROC_SNOOP = 2'd2,
        RELEASE    = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [NUM_CORE-1:0] gnt_proc_q,  gnt_proc_d;
    logic [NUM_CORE-1:0] gnt_snoop_q, gnt_snoop_d;
    logic [IDX_W-1:0]    proc_ptr_q,  proc_ptr_d;
    logic [IDX_W-1:0]    snoop_ptr_q, snoop_ptr_d;
    logic [IDX_W-1:0]    owner_q,     owner_d;
    logic [IDX_W-1:0]    snoop_idx_q, snoop_idx_d;

    logic [NUM_CORE-1:0] snoop_mask;
    logic [IDX_W-1:0]    proc_win;
    logic [IDX_W-1:0]    snoop_win;
    logic                owner_req;
    logic                snoop_req;

    // First requester at or after ptr, wrapping; returns 0 when nothing is requesting.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORE-1:0] req,
                                                 input logic [IDX_W-1:0]    ptr);
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CORE; i++) begin
            idx = (int'(ptr) + i) % NUM_CORE;
            if (!found && req[IDX_W'(idx)]) begin
                win   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_CORE - 1)) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [NUM_CORE-1:0] one_hot(input logic [IDX_W-1:0] idx);
        logic [NUM_CORE-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // The current proc owner can never win the snoop side.
    assign snoop_mask = bus_lv1_lv2_req_snoop & ~one_hot(owner_q);
    assign proc_win   = rr_pick(bus_lv1_lv2_req_proc, proc_ptr_q);
    assign snoop_win  = rr_pick(snoop_mask, snoop_ptr_q);
    assign owner_req  = bus_lv1_lv2_req_proc[owner_q];
    assign snoop_req  = bus_lv1_lv2_req_snoop[snoop_idx_q];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(ARB_TIMEOUT + 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q;
    logic             timeout_fire;

    assign timeout_fire = ((state_q == PROC) || (state_q == PROC_SNOOP)) &&
                          (cnt_q == CNT_W'(ARB_TIMEOUT - 1));
`endif

    always_comb begin
        state_d     = state_q;
        gnt_proc_d  = gnt_proc_q;
        gnt_snoop_d = gnt_snoop_q;
        proc_ptr_d  = proc_ptr_q;
        snoop_ptr_d = snoop_ptr_q;
        owner_d     = owner_q;
        snoop_idx_d = snoop_idx_q;

        case (state_q)
            IDLE: begin
                if (|bus_lv1_lv2_req_proc) begin
                    state_d    = PROC;
                    gnt_proc_d = one_hot(proc_win);
                    owner_d    = proc_win;
                    proc_ptr_d = next_idx(proc_win);
                end
            end
            PROC: begin
                // A proc drop in the same cycle as a snoop request takes precedence.
                if (!owner_req) begin
                    state_d    = RELEASE;
                    gnt_proc_d = '0;
                end else if (|snoop_mask) begin
                    state_d     = PROC_SNOOP;
                    gnt_snoop_d = one_hot(snoop_win);
                    snoop_idx_d = snoop_win;
                    snoop_ptr_d = next_idx(snoop_win);
                end
            end
            PROC_SNOOP: begin
                // The proc grant is held across the snoop even if its request already fell.
                if (!snoop_req) begin
                    gnt_snoop_d = '0;
                    if (owner_req) begin
                        state_d = PROC;
                    end else begin
                        state_d    = RELEASE;
                        gnt_proc_d = '0;
                    end
                end
            end
            RELEASE: begin
                state_d     = IDLE;
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
            end
            default: begin
                state_d     = IDLE;
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
            end
        endcase

`ifdef ARB_TIMEOUT_EN
        if (timeout_fire) begin
            state_d     = RELEASE;
            gnt_proc_d  = '0;
            gnt_snoop_d = '0;
            proc_ptr_d  = next_idx(owner_q);
        end

        cnt_d = cnt_q;
        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if ((state_q == PROC) || (state_q == PROC_SNOOP)) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            proc_ptr_q  <= '0;
            snoop_ptr_q <= '0;
            owner_q     <= '0;
            snoop_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            proc_ptr_q  <= proc_ptr_d;
            snoop_ptr_q <= snoop_ptr_d;
            owner_q     <= owner_d;
            snoop_idx_q <= snoop_idx_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_fire;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // No watchdog in this build; the parameter is accepted but has no effect.
    assign timeout_err = (ARB_TIMEOUT < 0);
`endif

    assign bus_lv1_lv2_gnt_proc  = gnt_proc_q;
    assign bus_lv1_lv2_gnt_snoop = gnt_snoop_q;
    assign arb_busy              = (state_q != IDLE);

endmodule

// File: tb/tb_lv1_lv2_bus_arbiter.sv
// Directed scoreboard bench for lv1_lv2_bus_arbiter (4 cores, timeout 8 when ARB_TIMEOUT_EN is defined).
module tb_lv1_lv2_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_proc;
    logic [3:0] req_snoop;
    logic [3:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic       arb_busy;
    logic       timeout_err;

    logic [9:0] exp_q[$];
    int         n_vec;
    int         n_err;

    lv1_lv2_bus_arbiter #(
        .NUM_CORE    (4),
        .ARB_TIMEOUT (8)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .bus_lv1_lv2_req_proc  (req_proc),
        .bus_lv1_lv2_req_snoop (req_snoop),
        .bus_lv1_lv2_gnt_proc  (gnt_proc),
        .bus_lv1_lv2_gnt_snoop (gnt_snoop),
        .arb_busy              (arb_busy),
        .timeout_err           (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] ev(input logic [3:0] gp, input logic [3:0] gs,
                                      input logic b, input logic t);
        return {gp, gs, b, t};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests; the expected outputs after the next edge go to the scoreboard.
    task automatic step(input logic [3:0] rp, input logic [3:0] rs,
                        input logic [9:0] exp, input string tag);
        logic [9:0] got;
        logic       inv_ok;
        req_proc  = rp;
        req_snoop = rs;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got    = {gnt_proc, gnt_snoop, arb_busy, timeout_err};
        inv_ok = $onehot0(gnt_proc) && $onehot0(gnt_snoop) &&
                 !((gnt_proc == 4'b0000) && (gnt_snoop != 4'b0000));
        check_eq(tag, 32'(got), 32'(exp_q.pop_front()));
        check_eq({tag, "_inv"}, 32'(inv_ok), 32'd1);
    endtask

    task automatic proc_round(input int g);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        step(4'hF, 4'h0, ev(oh, 4'h0, 1'b1, 1'b0), "rr_grant");
        step(4'hF, 4'h0, ev(oh, 4'h0, 1'b1, 1'b0), "rr_hold1");
        step(4'hF, 4'h0, ev(oh, 4'h0, 1'b1, 1'b0), "rr_hold2");
        step(4'hF & ~oh, 4'h0, ev(4'h0, 4'h0, 1'b1, 1'b0), "rr_release");
        // Requests seen during RELEASE must not produce a grant.
        step(4'hF, 4'h0, ev(4'h0, 4'h0, 1'b0, 1'b0), "rr_idle_gap");
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        req_proc  = 4'h0;
        req_snoop = 4'h0;

        step(4'hF, 4'hF, ev(4'h0, 4'h0, 1'b0, 1'b0), "reset0");
        step(4'hF, 4'hF, ev(4'h0, 4'h0, 1'b0, 1'b0), "reset1");
        rst_n = 1'b1;

        // Round robin 0,1,2,3 then wrap back to 0.
        for (int k = 0; k < 5; k++) proc_round(k % 4);

        // Core 2 owns the bus; its own snoop bit is ignored.
        step(4'b0100, 4'b0000, ev(4'b0100, 4'b0000, 1'b1, 1'b0), "c2_grant");
        step(4'b0100, 4'b0101, ev(4'b0100, 4'b0001, 1'b1, 1'b0), "c2_snoop0");
        step(4'b0100, 4'b0101, ev(4'b0100, 4'b0001, 1'b1, 1'b0), "c2_snoop0_hold");
        step(4'b0100, 4'b0100, ev(4'b0100, 4'b0000, 1'b1, 1'b0), "c2_snoop_end");
        step(4'b0100, 4'b0100, ev(4'b0100, 4'b0000, 1'b1, 1'b0), "c2_own_snoop_ign");
        step(4'b0000, 4'b0000, ev(4'b0000, 4'b0000, 1'b1, 1'b0), "c2_release");
        step(4'b0000, 4'b0000, ev(4'b0000, 4'b0000, 1'b0, 1'b0), "c2_idle");

        // Proc drop and snoop request in the same cycle: the drop wins.
        step(4'b1000, 4'b0000, ev(4'b1000, 4'b0000, 1'b1, 1'b0), "c3_grant");
        step(4'b0000, 4'b0001, ev(4'b0000, 4'b0000, 1'b1, 1'b0), "drop_beats_snoop");
        step(4'b0000, 4'b0000, ev(4'b0000, 4'b0000, 1'b0, 1'b0), "drop_idle");

        // Core 1 proc, core 3 snoop; proc drop deferred until the snoop ends.
        step(4'b0010, 4'b0000, ev(4'b0010, 4'b0000, 1'b1, 1'b0), "c1_grant");
        step(4'b0010, 4'b1000, ev(4'b0010, 4'b1000, 1'b1, 1'b0), "c1_snoop3");
        step(4'b0000, 4'b1000, ev(4'b0010, 4'b1000, 1'b1, 1'b0), "c1_defer1");
        step(4'b0000, 4'b1000, ev(4'b0010, 4'b1000, 1'b1, 1'b0), "c1_defer2");
        step(4'b0000, 4'b0000, ev(4'b0000, 4'b0000, 1'b1, 1'b0), "c1_release");
        step(4'b0000, 4'b0000, ev(4'b0000, 4'b0000, 1'b0, 1'b0), "c1_idle");

        // Snoop round robin, then reset in PROC_SNOOP.
        step(4'b0100, 4'b0000, ev(4'b0100, 4'b0000, 1'b1, 1'b0), "c2b_grant");
        step(4'b0100, 4'b1011, ev(4'b0100, 4'b0001, 1'b1, 1'b0), "snoop_rr0");
        step(4'b0100, 4'b1010, ev(4'b0100, 4'b0000, 1'b1, 1'b0), "snoop_rr_end");
        step(4'b0100, 4'b1010, ev(4'b0100, 4'b0010, 1'b1, 1'b0), "snoop_rr1");
        rst_n = 1'b0;
        step(4'b0100, 4'b1010, ev(4'b0000, 4'b0000, 1'b0, 1'b0), "rst_abort");
        rst_n = 1'b1;
        step(4'b1001, 4'b0000, ev(4'b0001, 4'b0000, 1'b1, 1'b0), "post_rst_core0");
        step(4'b0000, 4'b0000, ev(4'b0000, 4'b0000, 1'b1, 1'b0), "post_rst_release");
        step(4'b0000, 4'b0000, ev(4'b0000, 4'b0000, 1'b0, 1'b0), "post_rst_idle");

        // Long hold by core 0 while core 1 also requests.
        step(4'b0001, 4'b0000, ev(4'b0001, 4'b0000, 1'b1, 1'b0), "to_grant");
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 7; k++)
            step(4'b0011, 4'b0000, ev(4'b0001, 4'b0000, 1'b1, 1'b0), "to_hold");
        step(4'b0011, 4'b0000, ev(4'b0000, 4'b0000, 1'b1, 1'b1), "to_revoke");
        step(4'b0011, 4'b0000, ev(4'b0000, 4'b0000, 1'b0, 1'b0), "to_idle");
        step(4'b0011, 4'b0000, ev(4'b0010, 4'b0000, 1'b1, 1'b0), "to_next_core1");
`else
        for (int k = 0; k < 20; k++)
            step(4'b0011, 4'b0000, ev(4'b0001, 4'b0000, 1'b1, 1'b0), "no_to_hold");
        step(4'b0010, 4'b0000, ev(4'b0000, 4'b0000, 1'b1, 1'b0), "no_to_release");
        step(4'b0010, 4'b0000, ev(4'b0000, 4'b0000, 1'b0, 1'b0), "no_to_idle");
        step(4'b0010, 4'b0000, ev(4'b0010, 4'b0000, 1'b1, 1'b0), "no_to_core1");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
